event_counter_gen: RTL

Parametrised key-press event counter for the practicum board: a debounced, edge-detected push-button captures the slide-switch word onto the LEDs and conditionally increments a counter. The counter is shown in hexadecimal on a configurable number of seven-segment digits. This is the next-generation replacement for the lab-2 fixed-width counter, adding switch width, digit count, debounce length, a qualifying filter, and a wrap/saturate mode. It sits directly between board I/O pins and the top level.

---
 rtl/event_counter_gen.sv | 128 ++++++++++++
 1 files changed

// File: rtl/event_counter_gen.sv
// Key-press event counter: synchronised, debounced, edge-detected key captures the
// switch word onto the LEDs and (if qualified) advances a counter shown on hex digits.
module event_counter_gen #(
  parameter int SW_W            = 10,
  parameter int DIGITS          = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_ONES        = 0,
  parameter int SATURATE        = 0
) (
  input  logic                  clk100_i,
  input  logic                  rstn_i,
  input  logic [SW_W-1:0]       sw_i,
  input  logic                  key_i,
  output logic [SW_W-1:0]       ledr_o,
  output logic [7*DIGITS-1:0]   hex_o,
  output logic                  ovf_o
);

  localparam int CNT_W = 4 * DIGITS;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int POP_W = $clog2(SW_W + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_key_db;
  logic             r_key_db_d;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_strobe;
  logic [CNT_W-1:0] r_count;
  logic [SW_W-1:0]  r_ledr;
  logic             r_ovf;
  logic [7*DIGITS-1:0] r_hex;

  logic [POP_W-1:0] w_ones;
  logic             w_qualified;
  logic             w_cnt_max;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    w_ones = '0;
    for (int i = 0; i < SW_W; i++) begin
      w_ones = w_ones + POP_W'(sw_i[i]);
    end
  end

  assign w_qualified = (int'(w_ones) >= MIN_ONES);
  assign w_cnt_max   = &r_count;

  // key_db only follows key_s after it has differed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk100_i) begin
    if (!rstn_i) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_key_db   <= 1'b1;
      r_key_db_d <= 1'b1;
      r_db_cnt   <= '0;
      r_strobe   <= 1'b0;
    end else begin
      r_sync1 <= key_i;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_key_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_key_db <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
      r_key_db_d <= r_key_db;
      r_strobe   <= r_key_db_d & ~r_key_db;
    end
  end

  always_ff @(posedge clk100_i) begin
    if (!rstn_i) begin
      r_count <= '0;
      r_ledr  <= '0;
      r_ovf   <= 1'b0;
    end else if (r_strobe) begin
      r_ledr <= sw_i;
      if (w_qualified) begin
        if (!w_cnt_max) begin
          r_count <= r_count + CNT_W'(1);
        end else begin
          r_ovf <= 1'b1;
          if (SATURATE == 0) r_count <= '0;
        end
      end
    end
  end

  // Display trails the counter by one cycle.
  always_ff @(posedge clk100_i) begin
    if (!rstn_i) begin
      r_hex <= {DIGITS{7'b1000000}};
    end else begin
      for (int d = 0; d < DIGITS; d++) begin
        r_hex[7*d +: 7] <= seg7(r_count[4*d +: 4]);
      end
    end
  end

  assign ledr_o = r_ledr;
  assign hex_o  = r_hex;
  assign ovf_o  = r_ovf;

endmodule
